// File: rtl/wave_capture_pp_if.sv
// Sample/trigger/display inputs and RAM write outputs of the ping-pong wave capture.
// The DUT side uses the slave modport; the stimulus/RAM side uses master.
interface wave_capture_pp_if #(
  parameter int SAMPLE_W = 16,
  parameter int OUT_W    = 8,
  parameter int ADDR_W   = 8
);
  logic                new_sample_ready;
  logic [SAMPLE_W-1:0] new_sample_in;
  logic [1:0]          trig_mode;
  logic [SAMPLE_W-1:0] trig_level;
  logic                wave_display_idle;
  logic [ADDR_W:0]     write_address;
  logic                write_enable;
  logic [OUT_W-1:0]    write_sample;
  logic                read_index;
  logic [1:0]          cap_state;

  modport master (
    output new_sample_ready, new_sample_in, trig_mode, trig_level, wave_display_idle,
    input  write_address, write_enable, write_sample, read_index, cap_state
  );

  modport slave (
    input  new_sample_ready, new_sample_in, trig_mode, trig_level, wave_display_idle,
    output write_address, write_enable, write_sample, read_index, cap_state
  );
endinterface

// File: rtl/wave_capture_pp.sv
// Triggered ping-pong wave capture: scales signed samples to unsigned display values and
// fills one DEPTH-sample frame in the bank not currently owned by the display.
module wave_capture_pp #(
  parameter int SAMPLE_W     = 16,
  parameter int OUT_W        = 8,
  parameter int ADDR_W       = 8,
  parameter int AUTO_TIMEOUT = 1024
) (
  input logic              clk,
  input logic              reset,
  wave_capture_pp_if.slave bus
);

  localparam int CNT_W = (AUTO_TIMEOUT > 2) ? $clog2(AUTO_TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_ARMING = 2'b00,
    S_ARMED  = 2'b01,
    S_ACTIVE = 2'b10,
    S_WAIT   = 2'b11
  } state_t;

  state_t              state, state_next;
  logic [ADDR_W-1:0]   index, index_next;
  logic [CNT_W-1:0]    tcount, tcount_next;
  logic                prev_idle;
  logic                read_index_q;
  logic                flip;
  logic                do_write;
  logic                below;
  logic                rising_mode;
  logic                free_run;
  logic                auto_hit;
  logic                arm_cond;
  logic                fire_cond;
  logic                idle_rise;
  logic [OUT_W-1:0]    scaled;
  logic [ADDR_W:0]     wr_addr_q;
  logic                wr_en_q;
  logic [OUT_W-1:0]    wr_data_q;

  always_comb begin
    below       = $signed(bus.new_sample_in) < $signed(bus.trig_level);
    rising_mode = bus.trig_mode[0];
    free_run    = (bus.trig_mode == 2'b00);
    auto_hit    = (bus.trig_mode == 2'b11) && (tcount == CNT_W'(AUTO_TIMEOUT - 1));
    // Rising modes arm below the level and fire at/above it; falling is the mirror image.
    arm_cond    = rising_mode ? below : !below;
    fire_cond   = rising_mode ? !below : below;
    idle_rise   = bus.wave_display_idle && !prev_idle;
    scaled      = {~bus.new_sample_in[SAMPLE_W-1], bus.new_sample_in[SAMPLE_W-2 -: OUT_W-1]};
  end

  always_comb begin
    state_next  = state;
    index_next  = index;
    tcount_next = tcount;
    do_write    = 1'b0;
    flip        = 1'b0;

    case (state)
      S_ARMING, S_ARMED: begin
        if (bus.new_sample_ready) begin
          if (bus.trig_mode == 2'b11) begin
            tcount_next = tcount + 1'b1;
          end
          if (free_run || auto_hit || (state == S_ARMED && fire_cond)) begin
            state_next = S_ACTIVE;
            do_write   = 1'b1;
          end else if (state == S_ARMING && arm_cond) begin
            state_next = S_ARMED;
          end
        end
      end
      S_ACTIVE: begin
        if (bus.new_sample_ready) begin
          do_write = 1'b1;
        end
      end
      S_WAIT: begin
        // Samples arriving with the idle edge are dropped; only the bank flip matters.
        if (idle_rise) begin
          flip        = 1'b1;
          state_next  = S_ARMING;
          tcount_next = '0;
        end
      end
      default: state_next = S_ARMING;
    endcase

    if (do_write) begin
      index_next = index + 1'b1;
      if (index == '1) begin
        state_next = S_WAIT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_ARMING;
      index        <= '0;
      tcount       <= '0;
      prev_idle    <= 1'b0;
      read_index_q <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      state     <= state_next;
      index     <= index_next;
      tcount    <= tcount_next;
      prev_idle <= bus.wave_display_idle;
      wr_en_q   <= do_write;
      if (flip) begin
        read_index_q <= ~read_index_q;
      end
      if (do_write) begin
        wr_addr_q <= {~read_index_q, index};
        wr_data_q <= scaled;
      end
    end
  end

  assign bus.write_enable  = wr_en_q;
  assign bus.write_address = wr_addr_q;
  assign bus.write_sample  = wr_data_q;
  assign bus.read_index    = read_index_q;
  assign bus.cap_state     = state;

endmodule
